// File: rtl/gain_stage_pkg.sv
// Shared types and constants for the pedal input gain stage.
// Holds the FSM state enum, Q8.8 scaling and saturation helpers.
package gain_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    SAT  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int GAIN_FRAC = 8;
  localparam int ACC_W     = 32;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  // Clamp a full-width scaled value to the 16-bit sample range.
  function automatic logic [15:0] sat16(
    input logic signed [ACC_W-1:0] t
  );
    logic [15:0] r;
    if (t > 32'sd32767) begin
      r = SAT_MAX;
    end else if (t < -32'sd32768) begin
      r = SAT_MIN;
    end else begin
      r = t[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/gain_stage_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector.
// Ports: clk, rst (async high), async_in, pulse (1-cycle strobe).
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;
  logic pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta    <= 1'b0;
      sync    <= 1'b0;
      prev    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta    <= async_in;
      sync    <= meta;
      prev    <= sync;
      pulse_q <= sync & ~prev;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/gain_stage.sv
// Input gain stage: signed sample x unsigned Q8.8 gain, iterative.
// Ports: clk, rst, adc_clock, data_in, gain, bypass, data_out,
//        data_valid, data_ready, busy, overrun.
module gain_stage #(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = gain_stage_pkg::GAIN_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_clock,
  input  logic [DATA_W-1:0] data_in,
  input  logic [GAIN_W-1:0] gain,
  input  logic              bypass,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              overrun
);

  import gain_stage_pkg::*;

  localparam int CNT_W = $clog2(GAIN_W);

  logic              strobe;
  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] smp_q;
  logic [GAIN_W-1:0] gain_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  addend;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dout_q;
  logic              last_bit;

  edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (adc_clock),
    .pulse    (strobe)
  );

  assign last_bit = (cnt == CNT_W'(GAIN_W - 1));

  // Partial product for the current gain bit.
  assign addend =
    {{(ACC_W-DATA_W){smp_q[DATA_W-1]}}, smp_q} << cnt;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (strobe) begin
          state_nx = bypass ? OUT : MULT;
        end
      end
      MULT: begin
        if (last_bit) begin
          state_nx = SAT;
        end
      end
      SAT: begin
        state_nx = OUT;
      end
      OUT: begin
        if (data_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q  <= '0;
      gain_q <= '0;
      acc    <= '0;
      cnt    <= '0;
      dout_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (strobe) begin
            smp_q  <= data_in;
            gain_q <= gain;
            acc    <= '0;
            cnt    <= '0;
            // Bypass skips the multiplier entirely.
            if (bypass) begin
              dout_q <= data_in;
            end
          end
        end
        MULT: begin
          if (gain_q[cnt]) begin
            acc <= acc + addend;
          end
          cnt <= cnt + 1'b1;
        end
        SAT: begin
          dout_q <= sat16($signed(acc) >>> GAIN_FRAC);
        end
        OUT: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign data_out   = dout_q;
  assign data_valid = (state == OUT);
  assign busy       = (state != IDLE);
  // Strobe outside IDLE is dropped; in-flight work is untouched.
  assign overrun    = strobe & (state != IDLE);

endmodule

// File: tb/tb_gain_stage.sv
// Self-checking bench for gain_stage: table vectors, random
// vectors against an arithmetic model, and corner sequences.
module tb_gain_stage;

  logic        clk;
  logic        rst;
  logic        adc_clock;
  logic [15:0] data_in;
  logic [15:0] gain;
  logic        bypass;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] din;
    logic [15:0] g;
    logic        byp;
    logic [15:0] exp;
  } vec_t;

  gain_stage dut (
    .clk        (clk),
    .rst        (rst),
    .adc_clock  (adc_clock),
    .data_in    (data_in),
    .gain       (gain),
    .bypass     (bypass),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Real-valued product, floor-divided by 256, clamped.
  function automatic logic [15:0] model(input logic [15:0] d,
                                        input logic [15:0] g,
                                        input logic b);
    longint p;
    longint q;
    if (b) return d;
    p = longint'($signed(d)) * longint'({16'd0, g});
    q = p / 256;
    if ((p % 256 != 0) && (p < 0)) q = q - 1;
    if (q > 32767) return 16'h7FFF;
    if (q < -32768) return 16'h8000;
    return q[15:0];
  endfunction

  task automatic run(input vec_t v, input string nm);
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    data_in    = v.din;
    gain       = v.g;
    bypass     = v.byp;
    data_ready = 1'b1;
    adc_clock  = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 4) adc_clock = 1'b0;
    end while (!data_valid && n < 60);
    chk({nm, " latency"}, n, v.byp ? 4 : 21);
    chk({nm, " data"}, data_out, v.exp);
    @(posedge clk);
    #1;
    chk({nm, " valid_fall"}, data_valid, 1'b0);
  endtask

  vec_t tbl[10];

  initial begin
    vec_t v;
    int   ov;
    int   vc;
    logic stable;
    logic [15:0] held;

    rst        = 1'b1;
    adc_clock  = 1'b0;
    data_in    = '0;
    gain       = '0;
    bypass     = 1'b0;
    data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset data_out", data_out, 16'h0);
    chk("reset valid", data_valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset overrun", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    tbl[0] = '{16'h1234, 16'h0100, 1'b0, 16'h1234};
    tbl[1] = '{16'h5000, 16'h0200, 1'b0, 16'h7FFF};
    tbl[2] = '{16'hC000, 16'h0300, 1'b0, 16'h8000};
    tbl[3] = '{16'hFFFF, 16'h0080, 1'b0, 16'hFFFF};
    tbl[4] = '{16'h0001, 16'h0080, 1'b0, 16'h0000};
    tbl[5] = '{16'h8001, 16'h0000, 1'b1, 16'h8001};
    tbl[6] = '{16'h7FFF, 16'h0000, 1'b0, 16'h0000};
    tbl[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h8000};
    tbl[8] = '{16'h0100, 16'h0180, 1'b0, 16'h0180};
    tbl[9] = '{16'hFF00, 16'h0180, 1'b0, 16'hFE80};
    for (int i = 0; i < 10; i++) begin
      run(tbl[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      v.din = 16'($urandom);
      v.g   = 16'($urandom);
      if ($urandom_range(0, 1) == 1) v.g = 16'($urandom_range(0, 1023));
      v.byp = ($urandom_range(0, 7) == 0);
      v.exp = model(v.din, v.g, v.byp);
      run(v, $sformatf("rnd%0d", i));
    end

    // Backpressure with a dropped second strobe.
    repeat (2) @(posedge clk);
    @(negedge clk);
    data_in    = 16'h0400;
    gain       = 16'h0200;
    bypass     = 1'b0;
    data_ready = 1'b0;
    adc_clock  = 1'b1;
    vc = 0;
    do begin
      @(posedge clk);
      #1;
      vc++;
      if (vc == 4) adc_clock = 1'b0;
    end while (!data_valid && vc < 60);
    chk("bp latency", vc, 21);
    chk("bp data", data_out, 16'h0800);
    held   = data_out;
    stable = 1'b1;
    ov     = 0;
    data_in = 16'h1111;
    gain    = 16'h0100;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 10) adc_clock = 1'b1;
      if (c == 15) adc_clock = 1'b0;
      @(posedge clk);
      #1;
      if (!data_valid || data_out !== held) stable = 1'b0;
      if (overrun) ov++;
    end
    chk("bp hold", stable, 1'b1);
    chk("bp overrun pulses", ov, 1);
    chk("bp data after overrun", data_out, 16'h0800);
    @(negedge clk);
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp valid_fall", data_valid, 1'b0);
    chk("bp busy idle", busy, 1'b0);
    vc = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (data_valid) vc++;
    end
    chk("bp single transfer", vc, 0);

    // Reset in the middle of the multiply.
    @(negedge clk);
    data_in   = 16'h2222;
    gain      = 16'h0300;
    adc_clock = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      #1;
      if (c == 4) adc_clock = 1'b0;
    end
    chk("mid busy before rst", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst valid", data_valid, 1'b0);
    chk("rst data_out", data_out, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    vc = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (data_valid) vc++;
    end
    chk("rst no valid", vc, 0);
    v = '{16'h0321, 16'h0140, 1'b0, 16'h0000};
    v.exp = model(v.din, v.g, v.byp);
    run(v, "post_rst");

    // Strobes 19 cycles apart with ready high: no overrun.
    @(negedge clk);
    data_in    = 16'h0010;
    gain       = 16'h0100;
    data_ready = 1'b1;
    ov = 0;
    vc = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 0 || c == 19) adc_clock = 1'b1;
      if (c == 4 || c == 23) adc_clock = 1'b0;
      @(posedge clk);
      #1;
      if (overrun) ov++;
      if (data_valid) vc++;
      @(negedge clk);
    end
    chk("spacing overrun", ov, 0);
    chk("spacing results", vc, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
